// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
package dmem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

  typedef enum logic [0:0] {CLEAR, IDLE} state_e;

  // Response bookkeeping captured at the accept edge.
  typedef struct packed {
    logic       load;
    size_e      size;
    logic       uns;
    logic [2:0] off;
  } rsp_meta_t;

  function automatic logic [3:0] size_bytes(size_e sz);
    return 4'(4'd1 << sz);
  endfunction

  function automatic logic is_misaligned(size_e sz, logic [2:0] off);
    logic mis;
    case (sz)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      SZ_W:    mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bus between the EX stage and the data-memory LSU.
interface dmem_lsu_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 64
);
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  size_e             req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Word-organised synchronous RAM with per-byte write enables and a registered read port.
module dmem_array #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                     clk,
  input  logic [DATA_W/8-1:0]      we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);
  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately unreset; the LSU clears it after reset.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NB; b++) begin
      if (we[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/dmem_lsu.sv
// Load/store front end: post-reset clear FSM, alignment checks, byte-enable stores
// and sign/zero-extending loads over a single-cycle-latency handshake.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_lsu_if.slave  bus
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned IDX_W = ADDR_W - OFF_W;
  localparam int unsigned DEPTH = (2 ** ADDR_W) / NB;

  localparam logic [0:0] S_CLEAR = CLEAR;
  localparam logic [0:0] S_IDLE  = IDLE;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             ready_q, ready_d;
  logic             rsp_vld_q, rsp_vld_d;
  logic             err_q, err_d;
  rsp_meta_t        meta_q, meta_d;

  logic              accept, fault;
  logic [OFF_W-1:0]  off;
  logic [2:0]        off3;
  logic [IDX_W-1:0]  idx;
  logic [NB-1:0]     store_be;
  logic [DATA_W-1:0] store_data;
  logic [NB-1:0]     ram_we;
  logic              ram_re;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [DATA_W-1:0] shifted, ld_val;
  logic              ext;
  int unsigned       nbits;

  // Request decode: address split, fault detection, store lane placement.
  always_comb begin
    accept     = bus.req_valid & ready_q;
    off        = bus.req_addr[OFF_W-1:0];
    off3       = 3'(off);
    idx        = bus.req_addr[ADDR_W-1:OFF_W];
    fault      = (size_bytes(bus.req_size) > 4'(NB)) | is_misaligned(bus.req_size, off3);
    store_be   = NB'(NB'((16'd1 << size_bytes(bus.req_size)) - 16'd1) << off);
    store_data = bus.req_wdata << {off, 3'b000};
  end

  // The clear sweep owns the RAM port until the FSM reaches IDLE.
  always_comb begin
    ram_we    = '0;
    ram_re    = 1'b0;
    ram_addr  = idx;
    ram_wdata = store_data;
    if (state_q == S_CLEAR) begin
      ram_we    = '1;
      ram_addr  = clr_cnt_q;
      ram_wdata = '0;
    end else if (accept && !fault) begin
      if (bus.req_write) ram_we = store_be;
      else               ram_re = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    rsp_vld_d = accept;
    err_d     = err_q;
    meta_d    = meta_q;
    case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + IDX_W'(1);
        if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end
      end
      default: ready_d = 1'b1;
    endcase
    if (accept) begin
      err_d       = fault;
      meta_d.load = ~bus.req_write & ~fault;
      meta_d.size = bus.req_size;
      meta_d.uns  = bus.req_unsigned;
      meta_d.off  = off3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      rsp_vld_q <= 1'b0;
      err_q     <= 1'b0;
      meta_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      rsp_vld_q <= rsp_vld_d;
      err_q     <= err_d;
      meta_q    <= meta_d;
    end
  end

  dmem_array #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Load extension from the registered word; bits above the access width copy ext.
  always_comb begin
    shifted = ram_rdata >> {meta_q.off[OFF_W-1:0], 3'b000};
    nbits   = 32'd8 << meta_q.size;
    ext     = 1'b0;
    ld_val  = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i == nbits - 1) ext = shifted[i] & ~meta_q.uns;
    end
    for (int unsigned i = 0; i < DATA_W; i++) begin
      ld_val[i] = (i < nbits) ? shifted[i] : ext;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = rsp_vld_q;
  assign bus.resp_err   = err_q;
  assign bus.resp_rdata = meta_q.load ? ld_val : '0;
endmodule
